decode_hazard_ctrl: RTL and testbench
=====================================

Name: decode_hazard_ctrl

Overview:
- Operand-hazard controller for the decode stage: tracks in-flight register writers in a per-register scoreboard.
- Selects forwarded operands from EXE/MEM/WB and raises the decode stall when a needed operand is not yet available.
- Sits beside decode and drives the decode control interface signals stall, rs_value and rt_value.
- Contains a free-running stall-cycle counter for performance monitoring.

Parameters:
NREG, 32, number of architectural GPRs (index width = $clog2(NREG))
DATA_W, 32, register data width
SB_W, 2, width of each scoreboard pending counter (max in-flight writers per reg = 2^SB_W-1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  pipeline flush (exception/eret); kills all in-flight instructions
ds_valid  in  1  decode holds a valid instruction
ds_rs  in  5  decode source register 1
ds_rt  in  5  decode source register 2
ds_issue  in  1  decode pops instruction into EXE this cycle (ds_to_valid && es_allowin)
ds_rf_we  in  1  issuing instruction writes a GPR
ds_dest  in  5  issuing instruction destination
rf_rs_data  in  DATA_W  regfile read data for ds_rs
rf_rt_data  in  DATA_W  regfile read data for ds_rt
es_valid, ms_valid, ws_valid  in  1 each  stage holds a valid instruction
es_we, ms_we, ws_we  in  1 each  stage instruction writes a GPR
es_dest, ms_dest, ws_dest  in  5 each  stage destination
es_ready, ms_ready  in  1 each  stage result already computed (0 for load in EXE, mfc0/mul pending, etc.)
es_data, ms_data, ws_data  in  DATA_W each  stage result
ws_commit  in  1  WB writes regfile this cycle
stall  out  1  decode must not issue
rs_value  out  DATA_W  resolved rs operand
rt_value  out  DATA_W  resolved rt operand
stall_cnt  out  32  number of cycles with ds_valid && stall

Behaviour:
- Scoreboard: pend[r], SB_W bits, r=1..NREG-1; pend[0] is constant 0.
- Increment pend[ds_dest] on ds_issue && ds_rf_we && ds_dest!=0.
- Decrement pend[ws_dest] on ws_commit && ws_we && ws_dest!=0.
- Same register incremented and decremented in one cycle: value unchanged.
- Increment at max value: saturate and hold; this is never reached in legal operation (max 3 in flight: ES, MS, WS).
- Decrement at 0: hold 0.
- reset or flush: all pend cleared next edge; flush overrides a same-cycle issue/commit. stall_cnt is cleared by reset only.
- Forward select per source s (rs, rt), combinational, priority youngest first:
  - s==0 -> value 0, no stall.
  - es_valid&&es_we&&es_dest==s -> es_data; stall if !es_ready.
  - else ms match -> ms_data; stall if !ms_ready.
  - else ws match -> ws_data (always ready).
  - else pend[s]!=0 -> stall (safety; writer not visible in any stage).
  - else rf data.
- stall = ds_valid && (stall_rs || stall_rt). Output 0 when !ds_valid; rs_value/rt_value still reflect the forwarding mux.
- Stall is independent of es_allowin; backpressure remains decode's own handshake.
- stall_cnt: increments each cycle ds_valid&&stall; wraps 0xFFFFFFFF->0; reset value 0.
- Reset values: pend all 0, stall_cnt 0. stall is 0 during reset because it is gated by ds_valid, which decode holds 0 while in reset.
- Latency: forwarding and stall are 0-cycle combinational from the inputs; the scoreboard updates on the edge after issue/commit.
- The consumer issuing in the same cycle a writer enters EXE cannot happen: decode issues one instruction per cycle, so the producer is always already in ES when the consumer is examined.

Decomposition:
- Shared cpu package: reg_idx_t (5-bit), fwd_sel_t enum {FWD_RF, FWD_ES, FWD_MS, FWD_WS, FWD_ZERO}.
- One sub-module, hazard_fwd_mux, instantiated twice (rs, rt). Inputs: source index, stage info, pend bit. Outputs: fwd_sel, value, stall_src.
- Scoreboard and stall_cnt live in the top module.

Test Plan:
- addu $3 in ES (es_ready=1, es_data=0x11); decode reads rs=$3 -> rs_value=0x11, stall=0, scoreboard pend[3]=1.
- lw $5 in ES (es_ready=0); decode rt=$5 -> stall=1, stall_cnt +1 per cycle. lw moves to MS with ms_ready=1, ms_data=0xCAFE -> stall=0, rt_value=0xCAFE.
- $7 written in both ES (0xA) and MS (0xB) -> rs_value=0xA (youngest wins). rs=rt=$0 with ES dest $0 -> values 0, no stall.
- Issue writer to $9 and WB commit of $9 in the same cycle (pend[9]=1) -> pend[9] stays 1; next cycle with commit only -> 0.
- Fill pend[4]=2, pend[8]=1; assert flush together with ds_issue to $4 -> all pend 0 next cycle. stall_cnt retains its value; reset -> stall_cnt=0.
- stall_cnt forced near wrap (drive 2^32-1 stall cycles via a force/preload hook in sim) -> wraps to 0.

Source files
------------

// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types for the decode-stage operand hazard controller.
package decode_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    FWD_RF,
    FWD_ES,
    FWD_MS,
    FWD_WS,
    FWD_ZERO
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    logic     we;
    reg_idx_t dest;
  } stage_t;

  function automatic logic stage_hits(stage_t st, reg_idx_t src);
    return st.valid && st.we && (st.dest == src);
  endfunction

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode/pipeline-stage bundle seen by the hazard controller.
interface decode_hazard_ctrl_if
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) ();

  logic              ds_valid;
  reg_idx_t          ds_rs;
  reg_idx_t          ds_rt;
  logic              ds_issue;
  logic              ds_rf_we;
  reg_idx_t          ds_dest;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;

  logic              es_valid;
  logic              ms_valid;
  logic              ws_valid;
  logic              es_we;
  logic              ms_we;
  logic              ws_we;
  reg_idx_t          es_dest;
  reg_idx_t          ms_dest;
  reg_idx_t          ws_dest;
  logic              es_ready;
  logic              ms_ready;
  logic [DATA_W-1:0] es_data;
  logic [DATA_W-1:0] ms_data;
  logic [DATA_W-1:0] ws_data;
  logic              ws_commit;

  logic              stall;
  logic [DATA_W-1:0] rs_value;
  logic [DATA_W-1:0] rt_value;
  fwd_sel_t          rs_fwd;
  fwd_sel_t          rt_fwd;

  modport master (
    output ds_valid, ds_rs, ds_rt, ds_issue, ds_rf_we, ds_dest,
           rf_rs_data, rf_rt_data,
           es_valid, ms_valid, ws_valid, es_we, ms_we, ws_we,
           es_dest, ms_dest, ws_dest, es_ready, ms_ready,
           es_data, ms_data, ws_data, ws_commit,
    input  stall, rs_value, rt_value, rs_fwd, rt_fwd
  );

  modport slave (
    input  ds_valid, ds_rs, ds_rt, ds_issue, ds_rf_we, ds_dest,
           rf_rs_data, rf_rt_data,
           es_valid, ms_valid, ws_valid, es_we, ms_we, ws_we,
           es_dest, ms_dest, ws_dest, es_ready, ms_ready,
           es_data, ms_data, ws_data, ws_commit,
    output stall, rs_value, rt_value, rs_fwd, rt_fwd
  );

endinterface

// File: rtl/decode_hazard_ctrl_hazard_fwd_mux.sv
// Per-source forwarding select: youngest matching stage wins, scoreboard as fallback.
module hazard_fwd_mux
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  reg_idx_t          src,
  input  stage_t            es,
  input  stage_t            ms,
  input  stage_t            ws,
  input  logic              es_ready,
  input  logic              ms_ready,
  input  logic [DATA_W-1:0] es_data,
  input  logic [DATA_W-1:0] ms_data,
  input  logic [DATA_W-1:0] ws_data,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              pend_busy,
  output fwd_sel_t          fwd_sel,
  output logic [DATA_W-1:0] value,
  output logic              stall_src
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (src == '0)                fwd_sel = FWD_ZERO;
    else if (stage_hits(es, src)) fwd_sel = FWD_ES;
    else if (stage_hits(ms, src)) fwd_sel = FWD_MS;
    else if (stage_hits(ws, src)) fwd_sel = FWD_WS;
  end

  always_comb begin
    value     = rf_data;
    stall_src = 1'b0;
    unique case (fwd_sel)
      FWD_ZERO: value = '0;
      FWD_ES: begin
        value     = es_data;
        stall_src = !es_ready;
      end
      FWD_MS: begin
        value     = ms_data;
        stall_src = !ms_ready;
      end
      FWD_WS:   value = ws_data;
      // Writer issued but not visible in any stage: hold decode.
      FWD_RF:   stall_src = pend_busy;
      default: begin
        value     = rf_data;
        stall_src = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode operand hazard controller: per-register pending scoreboard, forwarding and stall counter.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SB_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  decode_hazard_ctrl_if.slave  hz,
  output logic [31:0]          stall_cnt
);

  localparam logic [SB_W-1:0] PEND_MAX = '1;

  logic [SB_W-1:0] pend_q [NREG];
  logic [SB_W-1:0] pend_d [NREG];
  logic            inc_hit [NREG];
  logic            dec_hit [NREG];
  logic [31:0]     stall_cnt_q;

  stage_t es_st, ms_st, ws_st;
  logic   stall_rs, stall_rt;
  logic   pend_rs, pend_rt;

  assign es_st = '{valid: hz.es_valid, we: hz.es_we, dest: hz.es_dest};
  assign ms_st = '{valid: hz.ms_valid, we: hz.ms_we, dest: hz.ms_dest};
  assign ws_st = '{valid: hz.ws_valid, we: hz.ws_we, dest: hz.ws_dest};

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      inc_hit[r] = hz.ds_issue && hz.ds_rf_we && (hz.ds_dest == reg_idx_t'(r));
      dec_hit[r] = hz.ws_commit && hz.ws_we && (hz.ws_dest == reg_idx_t'(r));
    end
  end

  // Coincident issue and commit on one register cancel, even when saturated.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (r == 0)
        pend_d[r] = '0;
      else if (inc_hit[r] && !dec_hit[r] && pend_q[r] != PEND_MAX)
        pend_d[r] = pend_q[r] + 1'b1;
      else if (dec_hit[r] && !inc_hit[r] && pend_q[r] != '0)
        pend_d[r] = pend_q[r] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (reset || flush) pend_q[r] <= '0;
      else                pend_q[r] <= pend_d[r];
    end
  end

  assign pend_rs = (pend_q[hz.ds_rs] != '0);
  assign pend_rt = (pend_q[hz.ds_rt] != '0);

  hazard_fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
    .src       (hz.ds_rs),
    .es        (es_st),
    .ms        (ms_st),
    .ws        (ws_st),
    .es_ready  (hz.es_ready),
    .ms_ready  (hz.ms_ready),
    .es_data   (hz.es_data),
    .ms_data   (hz.ms_data),
    .ws_data   (hz.ws_data),
    .rf_data   (hz.rf_rs_data),
    .pend_busy (pend_rs),
    .fwd_sel   (hz.rs_fwd),
    .value     (hz.rs_value),
    .stall_src (stall_rs)
  );

  hazard_fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
    .src       (hz.ds_rt),
    .es        (es_st),
    .ms        (ms_st),
    .ws        (ws_st),
    .es_ready  (hz.es_ready),
    .ms_ready  (hz.ms_ready),
    .es_data   (hz.es_data),
    .ms_data   (hz.ms_data),
    .ws_data   (hz.ws_data),
    .rf_data   (hz.rf_rt_data),
    .pend_busy (pend_rt),
    .fwd_sel   (hz.rt_fwd),
    .value     (hz.rt_value),
    .stall_src (stall_rt)
  );

  assign hz.stall = hz.ds_valid && (stall_rs || stall_rt);

  always_ff @(posedge clk) begin
    if (reset)         stall_cnt_q <= '0;
    else if (hz.stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl with a cycle-level reference model.
module tb_decode_hazard_ctrl;
  import decode_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit preload  = 1'b0;

  int          pend_m [32];
  logic [31:0] cnt_m;

  decode_hazard_ctrl_if #(.DATA_W(32)) hz ();

  decode_hazard_ctrl #(.NREG(32), .DATA_W(32), .SB_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .hz        (hz),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference operand resolution: scan stages youngest first, then scoreboard, then regfile.
  function automatic void resolve(input logic [4:0] s, input logic [31:0] rf,
                                  output logic [31:0] v, output bit st);
    bit          vld [3];
    bit          we  [3];
    logic [4:0]  d   [3];
    bit          rdy [3];
    logic [31:0] dat [3];
    vld = '{hz.es_valid, hz.ms_valid, hz.ws_valid};
    we  = '{hz.es_we, hz.ms_we, hz.ws_we};
    d   = '{hz.es_dest, hz.ms_dest, hz.ws_dest};
    rdy = '{hz.es_ready, hz.ms_ready, 1'b1};
    dat = '{hz.es_data, hz.ms_data, hz.ws_data};
    v  = rf;
    st = (pend_m[s] != 0);
    if (s == 5'd0) begin
      v  = 32'd0;
      st = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && we[i] && d[i] == s) begin
        v  = dat[i];
        st = !rdy[i];
        return;
      end
    end
  endfunction

  function automatic bit exp_stall();
    logic [31:0] v;
    bit          a, b;
    resolve(hz.ds_rs, hz.rf_rs_data, v, a);
    resolve(hz.ds_rt, hz.rf_rt_data, v, b);
    return hz.ds_valid && (a || b);
  endfunction

  always @(posedge clk) begin : model
    int nxt [32];
    bit st;
    st  = exp_stall();
    nxt = pend_m;
    if (reset || flush) begin
      foreach (nxt[i]) nxt[i] = 0;
    end else begin
      bit inc, dec;
      inc = hz.ds_issue && hz.ds_rf_we && hz.ds_dest != 0;
      dec = hz.ws_commit && hz.ws_we && hz.ws_dest != 0;
      if (inc && dec && hz.ds_dest == hz.ws_dest) begin
        inc = 1'b0;
        dec = 1'b0;
      end
      if (inc && nxt[hz.ds_dest] < 3) nxt[hz.ds_dest] = nxt[hz.ds_dest] + 1;
      if (dec && nxt[hz.ws_dest] > 0) nxt[hz.ws_dest] = nxt[hz.ws_dest] - 1;
    end
    pend_m <= nxt;
    if (reset)        cnt_m <= 32'd0;
    else if (preload) cnt_m <= 32'hFFFF_FFFF + {31'd0, st};
    else if (st)      cnt_m <= cnt_m + 32'd1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] vrs, vrt;
      bit          a, b;
      resolve(hz.ds_rs, hz.rf_rs_data, vrs, a);
      resolve(hz.ds_rt, hz.rf_rt_data, vrt, b);
      check("model_stall", {31'd0, hz.stall}, {31'd0, hz.ds_valid && (a || b)});
      check("model_rs_value", hz.rs_value, vrs);
      check("model_rt_value", hz.rt_value, vrt);
      if (!preload) check("model_stall_cnt", stall_cnt, cnt_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.ds_valid = 0; hz.ds_rs = 0; hz.ds_rt = 0; hz.ds_issue = 0; hz.ds_rf_we = 0; hz.ds_dest = 0;
    hz.rf_rs_data = 32'h0000_1111; hz.rf_rt_data = 32'h0000_2222;
    hz.es_valid = 0; hz.ms_valid = 0; hz.ws_valid = 0;
    hz.es_we = 0; hz.ms_we = 0; hz.ws_we = 0;
    hz.es_dest = 0; hz.ms_dest = 0; hz.ws_dest = 0;
    hz.es_ready = 0; hz.ms_ready = 0;
    hz.es_data = 0; hz.ms_data = 0; hz.ws_data = 0; hz.ws_commit = 0;
    flush = 0;
  endtask

  task automatic issue(input logic [4:0] dest);
    hz.ds_valid = 1; hz.ds_issue = 1; hz.ds_rf_we = 1; hz.ds_dest = dest;
  endtask

  task automatic no_issue();
    hz.ds_issue = 0; hz.ds_rf_we = 0; hz.ds_dest = 0;
  endtask

  initial begin
    logic [31:0] base;
    idle();
    reset = 1;
    tick(); tick();
    chk_en = 1;
    #2;
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_stall", {31'd0, hz.stall}, 32'd0);
    reset = 0;
    tick();

    // addu $3 forwarded from ES
    hz.ds_rs = 1; hz.ds_rt = 2;
    issue(5'd3);
    tick();
    no_issue();
    hz.es_valid = 1; hz.es_we = 1; hz.es_dest = 3; hz.es_ready = 1; hz.es_data = 32'h11;
    hz.ds_rs = 3;
    #2;
    check("es_fwd_rs_value", hz.rs_value, 32'h11);
    check("es_fwd_stall", {31'd0, hz.stall}, 32'd0);
    hz.es_valid = 0;
    #1;
    check("pend3_safety_stall", {31'd0, hz.stall}, 32'd1);
    tick();
    hz.ws_valid = 1; hz.ws_we = 1; hz.ws_dest = 3; hz.ws_commit = 1; hz.ws_data = 32'h11;
    #2;
    check("ws_fwd_rs_value", hz.rs_value, 32'h11);
    tick();
    idle();
    hz.ds_valid = 1; hz.ds_rs = 3; hz.rf_rs_data = 32'h33;
    #2;
    check("pend3_cleared_rf", hz.rs_value, 32'h33);
    check("pend3_cleared_stall", {31'd0, hz.stall}, 32'd0);
    tick();

    // lw $5: load-use stall, then MS forward
    hz.ds_rs = 0; hz.ds_rt = 0;
    issue(5'd5);
    tick();
    no_issue();
    hz.es_valid = 1; hz.es_we = 1; hz.es_dest = 5; hz.es_ready = 0; hz.es_data = 32'hDEAD;
    hz.ds_rt = 5;
    #2;
    check("lw_stall", {31'd0, hz.stall}, 32'd1);
    base = cnt_m;
    tick(); tick();
    check("lw_stall_cnt_plus2", stall_cnt, base + 32'd2);
    hz.es_valid = 0;
    hz.ms_valid = 1; hz.ms_we = 1; hz.ms_dest = 5; hz.ms_ready = 1; hz.ms_data = 32'hCAFE;
    #2;
    check("lw_ms_unstall", {31'd0, hz.stall}, 32'd0);
    check("lw_ms_rt_value", hz.rt_value, 32'hCAFE);
    tick();
    hz.ms_valid = 0;
    hz.ws_valid = 1; hz.ws_we = 1; hz.ws_dest = 5; hz.ws_commit = 1; hz.ws_data = 32'hCAFE;
    tick();
    idle();

    // youngest wins, $0 hardwired
    hz.ds_valid = 1; hz.ds_rs = 7;
    hz.es_valid = 1; hz.es_we = 1; hz.es_dest = 7; hz.es_ready = 1; hz.es_data = 32'hA;
    hz.ms_valid = 1; hz.ms_we = 1; hz.ms_dest = 7; hz.ms_ready = 1; hz.ms_data = 32'hB;
    #2;
    check("youngest_rs_value", hz.rs_value, 32'hA);
    hz.ds_rs = 0; hz.ds_rt = 0; hz.es_dest = 0; hz.es_ready = 0; hz.ms_dest = 0;
    #1;
    check("zero_rs_value", hz.rs_value, 32'd0);
    check("zero_rt_value", hz.rt_value, 32'd0);
    check("zero_stall", {31'd0, hz.stall}, 32'd0);
    tick();
    idle();

    // issue and commit of $9 in the same cycle
    issue(5'd9);
    tick();
    issue(5'd9);
    hz.ws_valid = 0; hz.ws_we = 1; hz.ws_dest = 9; hz.ws_commit = 1;
    tick();
    idle();
    hz.ds_valid = 1; hz.ds_rs = 9;
    #2;
    check("pend9_held", {31'd0, hz.stall}, 32'd1);
    hz.ds_valid = 0;
    hz.ws_we = 1; hz.ws_dest = 9; hz.ws_commit = 1;
    tick();
    idle();
    hz.ds_valid = 1; hz.ds_rs = 9;
    #2;
    check("pend9_released", {31'd0, hz.stall}, 32'd0);
    tick();

    // flush clears the scoreboard, not the counter
    issue(5'd4); tick();
    issue(5'd4); tick();
    issue(5'd8); tick();
    no_issue();
    hz.ds_rs = 4;
    #2;
    check("pend4_stall", {31'd0, hz.stall}, 32'd1);
    tick();
    base = cnt_m;
    hz.ds_valid = 0;
    flush = 1;
    issue(5'd4);
    hz.ds_valid = 0;
    tick();
    idle();
    hz.ds_valid = 1; hz.ds_rs = 4; hz.ds_rt = 8;
    #2;
    check("flush_pend_clear", {31'd0, hz.stall}, 32'd0);
    check("flush_keeps_cnt", stall_cnt, base);
    tick();

    // counter wrap via preload of the counter register
    hz.es_valid = 1; hz.es_we = 1; hz.es_dest = 4; hz.es_ready = 0;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    preload = 1;
    #1;
    check("preload_value", stall_cnt, 32'hFFFF_FFFF);
    tick();
    preload = 0;
    #1;
    check("wrap_to_zero", stall_cnt, 32'd0);
    tick();
    check("after_wrap_one", stall_cnt, 32'd1);

    idle();
    reset = 1;
    tick();
    reset = 0;
    #2;
    check("reset_clears_cnt", stall_cnt, 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
